// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared constants and FSM encoding for the TTC generator
package ttc_pkg;

    localparam int TTC_MXBXN     = 12;
    localparam int TTC_LHC_CYCLE = 3564;
    localparam int TTC_MXCNT     = 32;
    localparam int TTC_L1A_GAP   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } ttc_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count up on i_inc, stick at all-ones; reset and clear both zero it.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ttc_generator.sv
// rtl/ttc_generator.sv - BX0 / resync / L1A strobe generator with status counters
module ttc_generator
    import ttc_pkg::*;
#(
    parameter int MXBXN     = TTC_MXBXN,
    parameter int LHC_CYCLE = TTC_LHC_CYCLE,
    parameter int MXCNT     = TTC_MXCNT,
    parameter int L1A_GAP   = TTC_L1A_GAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [MXBXN-1:0] bx0_position,
    input  logic             resync_req,
    input  logic             l1a_req,
    input  logic [15:0]      l1a_period,
    output logic             ttc_bx0,
    output logic             ttc_resync,
    output logic             ttc_l1a,
    output logic [MXBXN-1:0] bxn_counter,
    output logic [MXCNT-1:0] bx0_sent_cnt,
    output logic [MXCNT-1:0] l1a_sent_cnt,
    output logic [MXCNT-1:0] l1a_drop_cnt
);

    localparam int               GAPW     = (L1A_GAP > 2) ? $clog2(L1A_GAP) : 1;
    localparam logic [GAPW-1:0]  GAP_LOAD = GAPW'(L1A_GAP - 1);
    localparam logic [MXBXN-1:0] LAST_BX  = MXBXN'(LHC_CYCLE - 1);
    localparam logic [MXBXN:0]   CYC_EXT  = (MXBXN + 1)'(LHC_CYCLE);

    ttc_state_t       r_state;
    ttc_state_t       w_state_next;
    logic [MXBXN-1:0] r_bx0_pos_lim;
    logic [MXBXN-1:0] r_bxn;
    logic             r_bx0;
    logic             r_resync;
    logic             r_l1a;
    logic             r_resync_pending;
    logic             r_l1a_pending;
    logic [15:0]      r_period_cnt;
    logic [GAPW-1:0]  r_gap;

    logic w_active;
    logic w_in_run;
    logic w_bx0_slot;
    logic w_resync_issue;
    logic w_l1a_issue;
    logic w_period_hit;
    logic w_l1a_event;
    logic w_l1a_drop;

    // Clamp the requested BX0 position into the orbit, one clock late.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bx0_pos_lim <= '0;
        end else if ({1'b0, bx0_position} >= CYC_EXT) begin
            r_bx0_pos_lim <= LAST_BX;
        end else begin
            r_bx0_pos_lim <= bx0_position;
        end
    end

    // Issue decisions; dropping enable suppresses everything immediately.
    always_comb begin
        w_active       = enable && (r_state != ST_IDLE);
        w_in_run       = enable && (r_state == ST_RUN);
        w_bx0_slot     = w_in_run && (r_bxn == r_bx0_pos_lim);
        w_resync_issue = w_in_run && r_resync_pending && !w_bx0_slot;
        w_l1a_issue    = w_in_run && r_l1a_pending && !w_bx0_slot &&
                         !w_resync_issue && (r_gap == '0);
        w_period_hit   = (l1a_period != 16'd0) && (r_period_cnt == (l1a_period - 16'd1));
        w_l1a_event    = w_in_run && !w_resync_issue && (l1a_req || w_period_hit);
        w_l1a_drop     = w_l1a_event && r_l1a_pending;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: RUN leaves to RESYNC for exactly one cycle; enable low always wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   w_state_next = ST_RUN;
            ST_RUN:    if (w_resync_issue) w_state_next = ST_RESYNC;
            ST_RESYNC: w_state_next = ST_RUN;
            default:   w_state_next = ST_IDLE;
        endcase
        if (!enable) begin
            w_state_next = ST_IDLE;
        end
    end

    // BXN counter, registered strobes, pending flags, period and gap counters.
    always_ff @(posedge clock) begin
        if (reset || !w_active) begin
            r_bxn            <= '0;
            r_bx0            <= 1'b0;
            r_resync         <= 1'b0;
            r_l1a            <= 1'b0;
            r_resync_pending <= 1'b0;
            r_l1a_pending    <= 1'b0;
            r_period_cnt     <= '0;
            r_gap            <= '0;
        end else begin
            r_bx0    <= w_bx0_slot;
            r_resync <= w_resync_issue;
            r_l1a    <= w_l1a_issue;

            if (w_resync_issue || (r_bxn == LAST_BX)) begin
                r_bxn <= '0;
            end else begin
                r_bxn <= r_bxn + MXBXN'(1);
            end

            if (w_resync_issue) begin
                r_resync_pending <= 1'b0;
            end else if (resync_req) begin
                r_resync_pending <= 1'b1;
            end

            if (w_resync_issue) begin
                r_l1a_pending <= 1'b0;
                r_period_cnt  <= '0;
                r_gap         <= '0;
            end else begin
                if (w_l1a_issue) begin
                    r_gap <= GAP_LOAD;
                end else if (r_gap != '0) begin
                    r_gap <= r_gap - GAPW'(1);
                end

                if (w_in_run) begin
                    if ((l1a_period == 16'd0) || w_period_hit) begin
                        r_period_cnt <= '0;
                    end else begin
                        r_period_cnt <= r_period_cnt + 16'd1;
                    end
                end

                if (w_l1a_issue) begin
                    r_l1a_pending <= 1'b0;
                end else if (w_l1a_event) begin
                    r_l1a_pending <= 1'b1;
                end
            end
        end
    end

    sat_counter #(.WIDTH(MXCNT)) u_bx0_sent (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (w_resync_issue),
        .i_inc   (w_bx0_slot),
        .o_count (bx0_sent_cnt)
    );

    sat_counter #(.WIDTH(MXCNT)) u_l1a_sent (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (w_resync_issue),
        .i_inc   (w_l1a_issue),
        .o_count (l1a_sent_cnt)
    );

    sat_counter #(.WIDTH(MXCNT)) u_l1a_drop (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (1'b0),
        .i_inc   (w_l1a_drop),
        .o_count (l1a_drop_cnt)
    );

    assign ttc_bx0     = r_bx0;
    assign ttc_resync  = r_resync;
    assign ttc_l1a     = r_l1a;
    assign bxn_counter = r_bxn;

endmodule

// File: tb/tb_ttc_generator.sv
// tb/tb_ttc_generator.sv - self-checking bench for ttc_generator
module tb_ttc_generator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] bx0_position = 12'd0;
    logic        resync_req = 1'b0;
    logic        l1a_req = 1'b0;
    logic [15:0] l1a_period = 16'd0;
    logic        ttc_bx0;
    logic        ttc_resync;
    logic        ttc_l1a;
    logic [11:0] bxn_counter;
    logic [31:0] bx0_sent_cnt;
    logic [31:0] l1a_sent_cnt;
    logic [31:0] l1a_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_n = 0;
    int exp_q[$];

    ttc_generator dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .bx0_position (bx0_position),
        .resync_req   (resync_req),
        .l1a_req      (l1a_req),
        .l1a_period   (l1a_period),
        .ttc_bx0      (ttc_bx0),
        .ttc_resync   (ttc_resync),
        .ttc_l1a      (ttc_l1a),
        .bxn_counter  (bxn_counter),
        .bx0_sent_cnt (bx0_sent_cnt),
        .l1a_sent_cnt (l1a_sent_cnt),
        .l1a_drop_cnt (l1a_drop_cnt)
    );

    always #10 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        tick_n++;
    endtask

    task automatic do_reset();
        enable = 1'b0; l1a_req = 1'b0; resync_req = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        enable = 1'b1; l1a_req = 1'b1; resync_req = 1'b1; reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({ttc_bx0, ttc_resync, ttc_l1a} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes got %b want 000", {ttc_bx0, ttc_resync, ttc_l1a});
        end
        n_cmp++;
        if (bxn_counter !== 12'd0) begin
            n_bad++; $display("FAIL reset_bxn got %0d want 0", bxn_counter);
        end
        n_cmp++;
        if ({bx0_sent_cnt, l1a_sent_cnt, l1a_drop_cnt} !== 96'd0) begin
            n_bad++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0",
                              bx0_sent_cnt, l1a_sent_cnt, l1a_drop_cnt);
        end
        reset = 1'b0; enable = 1'b0; l1a_req = 1'b0; resync_req = 1'b0;
        tick();
    endtask

    task automatic test_orbit();
        int got_other;
        bx0_position = 12'd100;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 10; k++) exp_q.push_back(102 + k * 3564);
        got_other = 0;
        enable = 1'b1; tick_n = 0;
        repeat (102 + 9 * 3564 + 20) begin
            tick();
            if (ttc_bx0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL orbit_bx0 unexpected strobe at clock %0d, none expected", tick_n);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (tick_n !== e) begin
                        n_bad++; $display("FAIL orbit_bx0 strobe at clock %0d want %0d", tick_n, e);
                    end
                end
            end
            if (ttc_resync || ttc_l1a) got_other++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL orbit_missing %0d strobes outstanding want 0", exp_q.size());
        end
        n_cmp++;
        if (bx0_sent_cnt !== 32'd10) begin
            n_bad++; $display("FAIL orbit_bx0_cnt got %0d want 10", bx0_sent_cnt);
        end
        n_cmp++;
        if (got_other !== 0) begin
            n_bad++; $display("FAIL orbit_other_strobes got %0d want 0", got_other);
        end
        enable = 1'b0;
    endtask

    task automatic test_limit();
        logic [11:0] prev_bxn;
        bit seen;
        bx0_position = 12'd4000;
        do_reset();
        exp_q.delete();
        exp_q.push_back(3565);
        seen = 0;
        prev_bxn = 12'd0;
        enable = 1'b1; tick_n = 0;
        while (!seen && tick_n < 3700) begin
            prev_bxn = bxn_counter;
            tick();
            if (ttc_bx0) begin
                int e;
                seen = 1;
                e = exp_q.pop_front();
                n_cmp++;
                if (tick_n !== e) begin
                    n_bad++; $display("FAIL limit_time strobe at clock %0d want %0d", tick_n, e);
                end
                n_cmp++;
                if (prev_bxn !== 12'd3563) begin
                    n_bad++; $display("FAIL limit_bxn prior bxn %0d want 3563", prev_bxn);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL limit_timeout no bx0 within 3700 clocks, want one");
        end
        enable = 1'b0;
    endtask

    task automatic test_collision();
        bx0_position = 12'd100;
        do_reset();
        enable = 1'b1; tick_n = 0;
        while (tick_n < 49) tick();
        l1a_req = 1'b1;
        tick(); tick();
        l1a_req = 1'b0;
        while (tick_n < 101) tick();
        n_cmp++;
        if ({bxn_counter, l1a_sent_cnt, l1a_drop_cnt} !== {12'd100, 32'd1, 32'd1}) begin
            n_bad++; $display("FAIL coll_pre bxn/sent/drop got %0d/%0d/%0d want 100/1/1",
                              bxn_counter, l1a_sent_cnt, l1a_drop_cnt);
        end
        resync_req = 1'b1;
        tick();
        resync_req = 1'b0;
        n_cmp++;
        if ({ttc_bx0, ttc_resync, ttc_l1a} !== 3'b100 || bx0_sent_cnt !== 32'd1) begin
            n_bad++; $display("FAIL coll_bx0 strobes %b cnt %0d want 100 cnt 1",
                              {ttc_bx0, ttc_resync, ttc_l1a}, bx0_sent_cnt);
        end
        tick();
        n_cmp++;
        if ({ttc_bx0, ttc_resync, ttc_l1a} !== 3'b010 || bxn_counter !== 12'd0) begin
            n_bad++; $display("FAIL coll_resync strobes %b bxn %0d want 010 bxn 0",
                              {ttc_bx0, ttc_resync, ttc_l1a}, bxn_counter);
        end
        tick();
        n_cmp++;
        if (bxn_counter !== 12'd1 || ttc_resync !== 1'b0) begin
            n_bad++; $display("FAIL coll_after bxn %0d resync %b want 1 0", bxn_counter, ttc_resync);
        end
        n_cmp++;
        if ({bx0_sent_cnt, l1a_sent_cnt, l1a_drop_cnt} !== {32'd0, 32'd0, 32'd1}) begin
            n_bad++; $display("FAIL coll_counters got %0d/%0d/%0d want 0/0/1",
                              bx0_sent_cnt, l1a_sent_cnt, l1a_drop_cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_gap();
        int req_at[5] = '{20, 21, 40, 43, 60};
        int want[4]  = '{21, 41, 44, 61};
        int k;
        bx0_position = 12'd3000;
        do_reset();
        exp_q.delete();
        foreach (want[i]) exp_q.push_back(want[i]);
        enable = 1'b1; tick_n = 0; k = 0;
        while (tick_n < 80) begin
            l1a_req = (k < 5 && (tick_n + 1) == req_at[k]) ? 1'b1 : 1'b0;
            if (l1a_req) k++;
            tick();
            if (ttc_l1a) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL gap_l1a unexpected strobe at clock %0d, none expected", tick_n);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (tick_n !== e) begin
                        n_bad++; $display("FAIL gap_l1a strobe at clock %0d want %0d", tick_n, e);
                    end
                end
            end
        end
        l1a_req = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL gap_missing %0d strobes outstanding want 0", exp_q.size());
        end
        n_cmp++;
        if (l1a_drop_cnt !== 32'd1 || l1a_sent_cnt !== 32'd4) begin
            n_bad++; $display("FAIL gap_counters drop %0d sent %0d want 1 4", l1a_drop_cnt, l1a_sent_cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_periodic();
        bx0_position = 12'd3000;
        l1a_period = 16'd10;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 100; i++) exp_q.push_back(12 + 10 * i);
        enable = 1'b1; tick_n = 0;
        repeat (1010) begin
            tick();
            if (ttc_l1a) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL periodic_l1a unexpected strobe at clock %0d, none expected", tick_n);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (tick_n !== e) begin
                        n_bad++; $display("FAIL periodic_l1a strobe at clock %0d want %0d", tick_n, e);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || l1a_sent_cnt !== 32'd100) begin
            n_bad++; $display("FAIL periodic_count outstanding %0d sent %0d want 0 100",
                              exp_q.size(), l1a_sent_cnt);
        end
        n_cmp++;
        if (l1a_drop_cnt !== 32'd0) begin
            n_bad++; $display("FAIL periodic_drop got %0d want 0", l1a_drop_cnt);
        end
        enable = 1'b0;
        l1a_period = 16'd0;
    endtask

    task automatic test_midrun(input bit use_reset);
        int strobes;
        bx0_position = 12'd3000;
        do_reset();
        enable = 1'b1; tick_n = 0;
        while (tick_n < 9) tick();
        l1a_req = 1'b1; tick(); l1a_req = 1'b0;
        tick();
        n_cmp++;
        if (ttc_l1a !== 1'b1) begin
            n_bad++; $display("FAIL midrun_first_l1a got %b want 1", ttc_l1a);
        end
        while (tick_n < 19) tick();
        l1a_req = 1'b1; tick(); l1a_req = 1'b0;
        if (use_reset) reset = 1'b1;
        else           enable = 1'b0;
        strobes = 0;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bxn_counter !== 12'd0) begin
            n_bad++; $display("FAIL midrun_bxn use_reset=%0d got %0d want 0", use_reset, bxn_counter);
        end
        n_cmp++;
        if (l1a_sent_cnt !== (use_reset ? 32'd0 : 32'd1)) begin
            n_bad++; $display("FAIL midrun_sent use_reset=%0d got %0d want %0d",
                              use_reset, l1a_sent_cnt, use_reset ? 0 : 1);
        end
        repeat (8) begin
            if (ttc_bx0 || ttc_resync || ttc_l1a) strobes++;
            tick();
        end
        n_cmp++;
        if (strobes !== 0) begin
            n_bad++; $display("FAIL midrun_strobes use_reset=%0d got %0d want 0", use_reset, strobes);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_orbit();
        test_limit();
        test_collision();
        test_gap();
        test_periodic();
        test_midrun(1'b0);
        test_midrun(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
